// File: rtl/nn_pkg.sv
// Shared geometry, frame type and capture FSM encoding for the nn classifier front end.
// Pure declarations: no latency, no flow control.
package nn_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int IDX_W      = 10;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_PIXELS - 1);

    typedef logic frame_t [IMG_PIXELS-1:0];

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } cap_state_t;

    function automatic logic binarise(input logic [7:0] pix, input logic [7:0] thresh);
        return (pix >= thresh);
    endfunction

endpackage

// File: rtl/nn_frame_bank.sv
// One 784x1 frame buffer: single-bit write port, whole-frame read port, synchronous clear.
// Write lands one cycle after we_i; read is the registered array; no backpressure.
module nn_frame_bank
    import nn_pkg::*;
(
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output frame_t           rd_o
);

    frame_t bits_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < IMG_PIXELS; i++) begin
                bits_q[i] <= 1'b0;
            end
        end else if (we_i) begin
            bits_q[idx_i] <= bit_i;
        end
    end

    assign rd_o = bits_q;

endmodule

// File: rtl/nn_frame_capture.sv
// Binarises a 28x28 pixel stream into a double-buffered frame for nn; publish 1 cycle after last pixel.
// pix_ready drops only while a finished frame waits for the previous one to be acked.
module nn_frame_capture
    import nn_pkg::*;
#(
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    input  logic       pix_sof,
    output frame_t     data,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic       sync_err,
    output logic [7:0] frame_count
);

    cap_state_t       state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_sel_q, wr_sel_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic [7:0]       frame_count_q, frame_count_d;

    logic             accept;
    logic [IDX_W-1:0] idx_eff;
    logic             pix_bit;
    logic             last_pix;
    logic             publish;

    frame_t           bank0_rd, bank1_rd;

    assign pix_ready = (state_q == FILL);
    assign accept    = pix_valid && pix_ready;
    assign idx_eff   = pix_sof ? '0 : wr_idx_q;
    assign pix_bit   = binarise(pix_data, THRESH);
    assign last_pix  = accept && (idx_eff == LAST_IDX);

    // A finished frame may publish immediately only if the read bank is free or being freed now.
    assign publish = ((state_q == FILL) && last_pix && (!frame_valid_q || frame_ack))
                  || ((state_q == HOLD) && frame_ack);

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        wr_sel_d      = wr_sel_q;
        frame_valid_d = frame_valid_q;
        sync_err_d    = 1'b0;
        frame_count_d = frame_count_q;

        if (accept) begin
            wr_idx_d   = last_pix ? '0 : idx_eff + 1'b1;
            sync_err_d = pix_sof && (wr_idx_q != '0);
        end

        case (state_q)
            FILL: if (last_pix && frame_valid_q && !frame_ack) state_d = HOLD;
            HOLD: if (frame_ack) state_d = FILL;
            default: state_d = FILL;
        endcase

        if (publish) begin
            wr_sel_d      = ~wr_sel_q;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
        end else if (frame_ack && frame_valid_q) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            wr_sel_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            wr_sel_q      <= wr_sel_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    nn_frame_bank u_bank0 (
        .clk_i (Clk),
        .clr_i (Reset),
        .we_i  (accept && !wr_sel_q),
        .idx_i (idx_eff),
        .bit_i (pix_bit),
        .rd_o  (bank0_rd)
    );

    nn_frame_bank u_bank1 (
        .clk_i (Clk),
        .clr_i (Reset),
        .we_i  (accept && wr_sel_q),
        .idx_i (idx_eff),
        .bit_i (pix_bit),
        .rd_o  (bank1_rd)
    );

    // Read bank is always the one not being written, so nn never sees a torn frame.
    always_comb begin
        for (int i = 0; i < IMG_PIXELS; i++) begin
            data[i] = wr_sel_q ? bank0_rd[i] : bank1_rd[i];
        end
    end

    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_nn_frame_capture.sv
// Scoreboarded bench for nn_frame_capture: model frames are queued on the last accept and
// compared whenever frame_count advances.
module tb_nn_frame_capture;
    import nn_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_sof;
    frame_t     data;
    logic       frame_valid;
    logic       frame_ack;
    logic       sync_err;
    logic [7:0] frame_count;

    int tests_run    = 0;
    int tests_failed = 0;

    frame_t     exp_q[$];
    frame_t     mdl_frame;
    frame_t     mdl_last;
    int         mdl_idx = 0;
    logic [7:0] prev_count = 8'd0;

    nn_frame_capture #(.THRESH(8'd128)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .data        (data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .sync_err    (sync_err),
        .frame_count (frame_count)
    );

    always #5 Clk = ~Clk;

    function automatic int diff_frame(input frame_t e);
        int n = 0;
        for (int i = 0; i < IMG_PIXELS; i++) begin
            if (data[i] !== e[i]) n++;
        end
        return n;
    endfunction

    // Advance one cycle, then pop and compare the scoreboard on every publish.
    task automatic tick();
        frame_t e;
        int     d;
        @(posedge Clk);
        #1;
        if (Reset === 1'b1) begin
            prev_count = frame_count;
        end else if (frame_count !== prev_count) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_publish: frame_count=%0d with no frame expected", frame_count);
            end else begin
                e = exp_q.pop_front();
                d = diff_frame(e);
                if (d != 0 || frame_valid !== 1'b1 || frame_count !== prev_count + 8'd1) begin
                    tests_failed++;
                    $display("FAIL sb_frame: %0d bits differ, frame_valid=%b count=%0d, want 0 diffs, 1, %0d",
                             d, frame_valid, frame_count, prev_count + 8'd1);
                end
            end
            prev_count = frame_count;
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic sof);
        if (sof) mdl_idx = 0;
        mdl_frame[mdl_idx] = (d >= 8'd128);
        mdl_idx++;
        if (mdl_idx == IMG_PIXELS) begin
            exp_q.push_back(mdl_frame);
            mdl_last = mdl_frame;
            mdl_idx  = 0;
        end
    endtask

    task automatic drive_pixel(input logic [7:0] d, input logic sof, input logic ack);
        bit done = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        frame_ack = ack;
        for (int w = 0; w < 2000 && !done; w++) begin
            if (pix_ready === 1'b1) begin
                model_accept(d, sof);
                done = 1'b1;
            end
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        frame_ack = 1'b0;
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pix_accept_timeout: pix_ready=%b after 2000 cycles, want 1", pix_ready);
        end
    endtask

    function automatic logic [7:0] pix_for(input int kind, input int i);
        case (kind)
            0:       return 8'd200;
            1:       return (i % 2 == 0) ? 8'd127 : 8'd128;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic stream(input int n, input int kind);
        for (int i = 0; i < n; i++) drive_pixel(pix_for(kind, i), 1'b0, 1'b0);
    endtask

    task automatic ack_pulse();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 8'd0;
        frame_ack = 1'b0;
        exp_q.delete();
        mdl_idx = 0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        frame_t z;
        int     d;
        for (int i = 0; i < IMG_PIXELS; i++) z[i] = 1'b0;
        d = diff_frame(z);
        tests_run++;
        if (frame_valid !== 1'b0 || pix_ready !== 1'b1 || sync_err !== 1'b0 || frame_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL %s_outputs: fv=%b rdy=%b serr=%b cnt=%0d, want 0 1 0 0",
                     tag, frame_valid, pix_ready, sync_err, frame_count);
        end
        tests_run++;
        if (d != 0) begin
            tests_failed++;
            $display("FAIL %s_data: %0d bits set, want 0", tag, d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_state("reset");
    endtask

    task automatic test_all_white();
        frame_t ones;
        for (int i = 0; i < IMG_PIXELS; i++) ones[i] = 1'b1;
        stream(IMG_PIXELS - 1, 0);
        tests_run++;
        if (frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL white_early_valid: frame_valid=%b before last pixel, want 0", frame_valid);
        end
        drive_pixel(8'd200, 1'b0, 1'b0);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_count !== 8'd1 || diff_frame(ones) != 0) begin
            tests_failed++;
            $display("FAIL white_publish: fv=%b cnt=%0d diffs=%0d, want 1 1 0",
                     frame_valid, frame_count, diff_frame(ones));
        end
        ack_pulse();
        tests_run++;
        if (frame_valid !== 1'b0 || diff_frame(ones) != 0) begin
            tests_failed++;
            $display("FAIL white_ack: fv=%b diffs=%0d, want 0 0", frame_valid, diff_frame(ones));
        end
    endtask

    task automatic test_threshold();
        frame_t alt;
        for (int i = 0; i < IMG_PIXELS; i++) alt[i] = (i % 2 == 1);
        stream(IMG_PIXELS, 1);
        tests_run++;
        if (data[0] !== 1'b0 || data[1] !== 1'b1 || diff_frame(alt) != 0 || frame_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL threshold: d0=%b d1=%b diffs=%0d cnt=%0d, want 0 1 0 2",
                     data[0], data[1], diff_frame(alt), frame_count);
        end
        ack_pulse();
    endtask

    task automatic test_hold();
        frame_t a;
        frame_t b;
        stream(IMG_PIXELS, 2);
        a = mdl_last;
        stream(IMG_PIXELS, 2);
        b = mdl_last;
        tests_run++;
        if (dut.state_q !== HOLD || pix_ready !== 1'b0 || frame_valid !== 1'b1 || diff_frame(a) != 0) begin
            tests_failed++;
            $display("FAIL hold_enter: state=%b rdy=%b fv=%b diffsA=%0d, want 1 0 1 0",
                     dut.state_q, pix_ready, frame_valid, diff_frame(a));
        end
        pix_valid = 1'b1;
        pix_data  = 8'd255;
        for (int i = 0; i < 3; i++) tick();
        pix_valid = 1'b0;
        tests_run++;
        if (pix_ready !== 1'b0 || frame_count !== 8'd3 || diff_frame(a) != 0) begin
            tests_failed++;
            $display("FAIL hold_stall: rdy=%b cnt=%0d diffsA=%0d, want 0 3 0",
                     pix_ready, frame_count, diff_frame(a));
        end
        ack_pulse();
        tests_run++;
        if (frame_valid !== 1'b1 || pix_ready !== 1'b1 || frame_count !== 8'd4 || diff_frame(b) != 0) begin
            tests_failed++;
            $display("FAIL hold_release: fv=%b rdy=%b cnt=%0d diffsB=%0d, want 1 1 4 0",
                     frame_valid, pix_ready, frame_count, diff_frame(b));
        end
        ack_pulse();
        tests_run++;
        if (frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_final_ack: fv=%b, want 0", frame_valid);
        end
    endtask

    task automatic test_sof_resync();
        int pulses = 0;
        int early  = 0;
        stream(299, 2);
        drive_pixel(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        tests_run++;
        if (sync_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL sof_sync_err: sync_err=%b after mid-frame sof, want 1", sync_err);
        end
        for (int k = 0; k < IMG_PIXELS - 1; k++) begin
            drive_pixel(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            if (sync_err === 1'b1) pulses++;
            if (k < IMG_PIXELS - 2 && frame_valid !== 1'b0) early++;
        end
        tests_run++;
        if (pulses != 0 || early != 0) begin
            tests_failed++;
            $display("FAIL sof_quiet: extra sync_err=%0d early valid cycles=%0d, want 0 0", pulses, early);
        end
        tests_run++;
        if (frame_valid !== 1'b1 || frame_count !== 8'd5) begin
            tests_failed++;
            $display("FAIL sof_publish: fv=%b cnt=%0d after 784 post-sof accepts, want 1 5",
                     frame_valid, frame_count);
        end
    endtask

    task automatic test_ack_same_cycle();
        stream(IMG_PIXELS - 1, 2);
        drive_pixel(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        tests_run++;
        if (frame_valid !== 1'b1 || dut.state_q !== FILL || pix_ready !== 1'b1 ||
            frame_count !== 8'd6 || diff_frame(mdl_last) != 0) begin
            tests_failed++;
            $display("FAIL ack_publish: fv=%b state=%b rdy=%b cnt=%0d diffs=%0d, want 1 0 1 6 0",
                     frame_valid, dut.state_q, pix_ready, frame_count, diff_frame(mdl_last));
        end
    endtask

    task automatic test_reset_midframe();
        stream(500, 2);
        do_reset();
        check_reset_state("midreset");
        stream(IMG_PIXELS, 2);
        tests_run++;
        if (frame_valid !== 1'b1 || frame_count !== 8'd1 || diff_frame(mdl_last) != 0) begin
            tests_failed++;
            $display("FAIL midreset_publish: fv=%b cnt=%0d diffs=%0d, want 1 1 0",
                     frame_valid, frame_count, diff_frame(mdl_last));
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d frames never published, want 0", exp_q.size());
        end
    endtask

    initial begin
        Reset     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        pix_sof   = 1'b0;
        frame_ack = 1'b0;
        test_reset();
        test_all_white();
        test_threshold();
        test_hold();
        test_sof_resync();
        test_ack_same_cycle();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
